// File: rtl/de_morgan_pkg.sv
// Shared encodings for the De Morgan exhaustive sweep checker.
package de_morgan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic LAW_NOR  = 1'b0;
    localparam logic LAW_NAND = 1'b1;

endpackage

// File: rtl/de_morgan_eval.sv
// Combinational evaluation of one vector: direct form vs De Morgan form,
// with an optional single-bit corruption of the De Morgan side.
module de_morgan_eval
    import de_morgan_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         law,
    input  logic         flip,
    output logic [W-1:0] lhs,
    output logic [W-1:0] rhs,
    output logic         match
);

    logic [W-1:0] rhs_raw;

    always_comb begin
        if (law == LAW_NAND) begin
            lhs     = ~(a & b);
            rhs_raw = ~a | ~b;
        end else begin
            lhs     = ~(a | b);
            rhs_raw = ~a & ~b;
        end
        rhs    = rhs_raw;
        rhs[0] = rhs_raw[0] ^ flip;
    end

    assign match = (lhs == rhs);

endmodule

// File: rtl/de_morgan_sweep.sv
// Self-running exhaustive De Morgan checker: issues every {a,b} pair into a
// one-deep stage, evaluates it on the next edge, and tallies pass/fail.
module de_morgan_sweep
    import de_morgan_pkg::*;
#(
    parameter int W  = 2,
    parameter int CW = 2*W+1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            law,
    input  logic            fault_en,
    input  logic [2*W-1:0]  fault_idx,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt,
    output logic            fail_seen,
    output logic [2*W-1:0]  first_fail
);

    state_t          state, state_nxt;
    logic [2*W-1:0]  idx, stg_idx, fault_idx_q;
    logic            stg_vld, law_q, fault_en_q;
    logic            go, last, flip, match;
    logic [W-1:0]    lhs, rhs;
    logic [2*W-1:0]  eval_unused;

    assign go   = (state == IDLE || state == DONE) && start && !abort;
    assign last = (idx == {(2*W){1'b1}});
    assign flip = fault_en_q && (stg_idx == fault_idx_q);

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = RUN;
                RUN:        if (last)  state_nxt = FLUSH;
                FLUSH:      state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    de_morgan_eval #(.W(W)) u_eval (
        .a     (stg_idx[2*W-1:W]),
        .b     (stg_idx[W-1:0]),
        .law   (law_q),
        .flip  (flip),
        .lhs   (lhs),
        .rhs   (rhs),
        .match (match)
    );

    // Both forms are observable on the sub-module for debug; only match is tallied.
    assign eval_unused = {lhs, rhs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            stg_idx     <= '0;
            stg_vld     <= 1'b0;
            law_q       <= 1'b0;
            fault_en_q  <= 1'b0;
            fault_idx_q <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_seen   <= 1'b0;
            first_fail  <= '0;
        end else begin
            // Abort drops whatever sits in the stage without tallying it.
            stg_vld <= (state == RUN) && !abort;
            if (state == RUN && !abort) begin
                stg_idx <= idx;
                idx     <= idx + (2*W)'(1);
            end

            if (go) begin
                law_q       <= law;
                fault_en_q  <= fault_en;
                fault_idx_q <= fault_idx;
                idx         <= '0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                fail_seen   <= 1'b0;
                first_fail  <= '0;
            end else if (stg_vld && !abort) begin
                if (match) begin
                    pass_cnt <= pass_cnt + CW'(1);
                end else begin
                    fail_cnt <= fail_cnt + CW'(1);
                    if (!fail_seen) begin
                        fail_seen  <= 1'b1;
                        first_fail <= stg_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_de_morgan_sweep.sv
// Scoreboard bench: stimulus pushes model results per sweep, monitors pop on done.
module tb_de_morgan_sweep;

    typedef struct {
        int pass_n;
        int fail_n;
        int seen;
        int first;
        int scyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic       start2, abort2, law2, fe2, busy2, done2, seen2;
    logic [3:0] fi2, ff2;
    logic [4:0] pc2, fc2;
    logic       start1, abort1, law1, fe1, busy1, done1, seen1;
    logic [1:0] fi1, ff1;
    logic [2:0] pc1, fc1;

    exp_t q2[$];
    exp_t q1[$];
    exp_t e2m, e1m;
    logic done2_q = 1'b0, done1_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    de_morgan_sweep #(.W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .law(law2),
        .fault_en(fe2), .fault_idx(fi2), .busy(busy2), .done(done2),
        .pass_cnt(pc2), .fail_cnt(fc2), .fail_seen(seen2), .first_fail(ff2)
    );

    de_morgan_sweep #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .law(law1),
        .fault_en(fe1), .fault_idx(fi1), .busy(busy1), .done(done1),
        .pass_cnt(pc1), .fail_cnt(fc1), .fail_seen(seen1), .first_fail(ff1)
    );

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk the first `upto` vectors applying the two forms of the law.
    function automatic exp_t model(int w, int lw, int fe, int fi, int upto);
        exp_t e;
        int   m;
        e = '{0, 0, 0, 0, 0};
        m = (1 << w) - 1;
        for (int i = 0; i < upto; i++) begin
            int a, b, l, r;
            a = (i >> w) & m;
            b = i & m;
            l = lw ? (~(a & b)) & m : (~(a | b)) & m;
            r = lw ? ((~a) | (~b)) & m : ((~a) & (~b)) & m;
            if (fe != 0 && i == fi) r = r ^ 1;
            if (l == r) e.pass_n++;
            else begin
                if (e.seen == 0) begin
                    e.seen  = 1;
                    e.first = i;
                end
                e.fail_n++;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done2 && !done2_q) begin
            if (q2.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL w2 done: got unexpected done, required none");
            end else begin
                e2m = q2.pop_front();
                chk("w2 pass_cnt",   int'(pc2),   e2m.pass_n);
                chk("w2 fail_cnt",   int'(fc2),   e2m.fail_n);
                chk("w2 fail_seen",  int'(seen2), e2m.seen);
                chk("w2 first_fail", int'(ff2),   e2m.first);
                chk("w2 latency",    cyc - e2m.scyc, 17);
                chk("w2 busy@done",  int'(busy2), 0);
            end
        end
        done2_q <= done2;
    end

    always @(negedge clk) begin
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL w1 done: got unexpected done, required none");
            end else begin
                e1m = q1.pop_front();
                chk("w1 pass_cnt",   int'(pc1),   e1m.pass_n);
                chk("w1 fail_cnt",   int'(fc1),   e1m.fail_n);
                chk("w1 fail_seen",  int'(seen1), e1m.seen);
                chk("w1 first_fail", int'(ff1),   e1m.first);
                chk("w1 latency",    cyc - e1m.scyc, 5);
            end
        end
        done1_q <= done1;
    end

    task automatic go2(int lw, int fe, int fi, bit push);
        exp_t e;
        @(negedge clk);
        law2 = lw[0]; fe2 = fe[0]; fi2 = fi[3:0]; start2 = 1'b1;
        if (push) begin
            e = model(2, lw, fe, fi & 15, 16);
            e.scyc = cyc + 1;
            q2.push_back(e);
        end
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic go1(int lw, int fe, int fi, bit push);
        exp_t e;
        @(negedge clk);
        law1 = lw[0]; fe1 = fe[0]; fi1 = fi[1:0]; start1 = 1'b1;
        if (push) begin
            e = model(1, lw, fe, fi & 3, 4);
            e.scyc = cyc + 1;
            q1.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait2();
        int n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w2 done within bound", int'(done2), 1);
    endtask

    task automatic wait1();
        int n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w1 done within bound", int'(done1), 1);
    endtask

    initial begin
        exp_t ea;
        int   n;
        rst_n = 1'b0;
        start2 = 0; abort2 = 0; law2 = 0; fe2 = 0; fi2 = '0;
        start1 = 0; abort1 = 0; law1 = 0; fe1 = 0; fi1 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy",       int'(busy2), 0);
        chk("reset done",       int'(done2), 0);
        chk("reset pass_cnt",   int'(pc2),   0);
        chk("reset fail_cnt",   int'(fc2),   0);
        chk("reset fail_seen",  int'(seen2), 0);
        chk("reset first_fail", int'(ff2),   0);
        rst_n = 1'b1;

        // Plain NOR law, then NAND law with one injected fault.
        go2(0, 0, 0, 1); wait2();
        go2(1, 1, 4'b1010, 1); wait2();

        // Second start mid-sweep with different config must be ignored.
        go2(0, 0, 0, 1);
        repeat (4) @(negedge clk);
        law2 = 1'b1; fe2 = 1'b1; fi2 = 4'd3; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait2();

        // Abort sampled on edge E0+8 together with start.
        go2(0, 0, 0, 0);
        repeat (7) @(negedge clk);
        abort2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0; start2 = 1'b0;
        ea = model(2, 0, 0, 0, 6);
        chk("abort busy",      int'(busy2), 0);
        chk("abort done",      int'(done2), 0);
        chk("abort pass_cnt",  int'(pc2),   ea.pass_n);
        chk("abort fail_cnt",  int'(fc2),   ea.fail_n);
        @(negedge clk);
        chk("abort stays idle", int'(busy2), 0);
        chk("abort pass hold",  int'(pc2),   ea.pass_n);

        // Asynchronous reset between edges mid-sweep.
        go2(1, 1, 2, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy",       int'(busy2), 0);
        chk("async rst pass_cnt",   int'(pc2),   0);
        chk("async rst fail_cnt",   int'(fc2),   0);
        chk("async rst fail_seen",  int'(seen2), 0);
        chk("async rst first_fail", int'(ff2),   0);
        #1 rst_n = 1'b1;
        go2(0, 0, 0, 1); wait2();

        for (int k = 0; k < 4; k++) begin
            go2(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), 1);
            wait2();
        end

        // W=1: fault on the last index, then restart straight from DONE.
        go1(0, 1, 3, 1); wait1();
        go1(0, 0, 0, 1); wait1();
        for (int k = 0; k < 3; k++) begin
            go1(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), 1);
            wait1();
        end

        n = 0;
        while ((q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", q1.size() + q2.size(), 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
